// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, function codes, field positions, loader FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package isa_pkg;

  localparam int INSTR_W = 32;

  // Field bit positions (LSB of each field) and widths
  localparam int OP_LSB     = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  localparam int OP_W     = 6;
  localparam int REG_W    = 5;
  localparam int FUNC_W   = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h03;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_I22   = 6'h22;
  localparam logic [5:0] OP_I12   = 6'h12;
  localparam logic [5:0] OP_I28   = 6'h28;
  localparam logic [5:0] OP_I2B   = 6'h2B;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  // R-type function codes
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_LWN = 6'h21;
  localparam logic [5:0] FN_SWN = 6'h13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/instr_field_encoder.sv
// Packs an instruction field bundle into a 32-bit word and flags unknown opcodes.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports: opcode/func/rs/rt/rd/shamt/imm/target in; word (encoded), illegal (opcode not in ISA) out.
module instr_field_encoder
  import isa_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[OP_LSB +: OP_W] = opcode;
    case (opcode)
      OP_RTYPE: begin
        word[RS_LSB    +: REG_W]  = rs;
        word[RT_LSB    +: REG_W]  = rt;
        word[RD_LSB    +: REG_W]  = rd;
        word[SHAMT_LSB +: REG_W]  = shamt;
        word[FUNC_LSB  +: FUNC_W] = func;
      end
      OP_J, OP_JAL: begin
        word[TARGET_LSB +: TARGET_W] = target;
      end
      OP_LUI: begin
        // rs field stays zero for lui regardless of the supplied rs
        word[RT_LSB  +: REG_W] = rt;
        word[IMM_LSB +: IMM_W] = imm;
      end
      OP_ADDI, OP_ANDI, OP_XORI, OP_BNE, OP_BEQ,
      OP_I22, OP_I12, OP_I28, OP_I2B: begin
        word[RS_LSB  +: REG_W] = rs;
        word[RT_LSB  +: REG_W] = rt;
        word[IMM_LSB +: IMM_W] = imm;
      end
      default: begin
        // Unknown opcodes still get an I-type layout; the loader decides whether to trap
        illegal = 1'b1;
        word[RS_LSB  +: REG_W] = rs;
        word[RT_LSB  +: REG_W] = rt;
        word[IMM_LSB +: IMM_W] = imm;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts instruction field bundles, encodes them and writes them to instruction memory.
// Latency: 1 cycle from accepting handshake to imem write; one word per 2 cycles.
// Backpressure: in_ready high only in ACCEPT; session ends on in_last or after DEPTH words.
//
// Ports: clk, rst (async active-high); start/base_addr open a session; in_valid/in_ready plus
// in_* fields carry bundles; imem_we/imem_addr/imem_wdata write port; busy/done/err/word_count status.
// Optional feature: define ILLEGAL_TRAP_EN to drop unknown opcodes, set err and end the session.
module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              base_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_opcode,
  input  logic [5:0]               in_func,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [15:0]              in_imm,
  input  logic [25:0]              in_target,
  input  logic                     in_last,
  output logic                     imem_we,
  output logic [31:0]              imem_addr,
  output logic [31:0]              imem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   word_count
);

  localparam int WCW = $clog2(DEPTH) + 1;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t         state_q, state_d;
  logic [31:0]    base_q, base_d;
  logic [31:0]    word_q, word_d;
  logic           last_q, last_d;
  logic           err_q, err_d;
  logic [WCW-1:0] wc_q, wc_d;
  logic [WCW-1:0] wc_inc;
  logic [31:0]    enc_word;
  logic           enc_illegal;

  instr_field_encoder u_enc (
    .opcode  (in_opcode),
    .func    (in_func),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign wc_inc     = wc_q + WCW'(1);
  assign err        = err_q;
  assign word_count = wc_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_d     = word_q;
    last_d     = last_q;
    err_d      = err_q;
    wc_d       = wc_q;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          wc_d    = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (TRAP_EN && enc_illegal) begin
            // Trapped opcode: nothing is written, session closes with err set
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            word_d  = enc_word;
            last_d  = in_last;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        busy       = 1'b1;
        imem_we    = 1'b1;
        // Wraps modulo 2^32 by construction of the 32-bit add
        imem_addr  = base_q + (32'(wc_q) << 2);
        imem_wdata = word_q;
        wc_d       = wc_inc;
        if (last_q || (wc_inc == WCW'(DEPTH))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
      wc_q    <= wc_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed sessions, expected writes queued, monitor compares.
// Latency: n/a.
// Backpressure: n/a.
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_func;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  word_count;

  instr_encoder_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_func    (in_func),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int  total    = 0;
  int  bad      = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (imem_we === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, no write expected",
                   imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", imem_addr, e.addr);
          chk("wr_data", imem_wdata, e.data);
        end
      end else begin
        chk("quiet_addr", imem_addr, 32'h0);
        chk("quiet_data", imem_wdata, 32'h0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic do_start(input logic [31:0] base);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic last,
                      input int budget, output bit ok);
    in_opcode = op;  in_rs = rs;  in_rt = rt;  in_rd = rd;  in_shamt = sh;
    in_func   = fn;  in_imm = imm; in_target = tgt; in_last = last;
    in_valid  = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 30 && done_cnt < target; i++) @(negedge clk);
    chk("done_seen", done_cnt, target);
    @(negedge clk);
    chkb("done_one_cycle", done, 1'b0);
    chkb("busy_after_done", busy, 1'b0);
  endtask

  initial begin : stim
    bit ok;
    int d0;
    int w0;
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_opcode = '0; in_func = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0; in_target = '0; in_last = 1'b0;
    #1;
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_imem_we", imem_we, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_err", err, 1'b0);
    chk("rst_word_count", 32'(word_count), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single addi, base 0
    d0 = done_cnt; w0 = wr_cnt;
    do_start(32'h0000_0000);
    chkb("start_busy", busy, 1'b1);
    chkb("start_in_ready", in_ready, 1'b1);
    chk("start_wc", 32'(word_count), 32'h0);
    exp_q.push_back('{addr: 32'h0000_0000, data: 32'h2422_0005});
    send(6'h09, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0, 1'b1, 20, ok);
    chkb("addi_accepted", ok, 1'b1);
    wait_done(d0 + 1);
    chk("addi_wc", 32'(word_count), 32'h1);
    chk("addi_writes", wr_cnt - w0, 32'd1);

    // R-type then j
    d0 = done_cnt; w0 = wr_cnt;
    do_start(32'h0000_1000);
    exp_q.push_back('{addr: 32'h0000_1000, data: 32'h0C64_2821});
    exp_q.push_back('{addr: 32'h0000_1004, data: 32'h0800_0100});
    send(6'h03, 5'd3, 5'd4, 5'd5, 5'd0, 6'h21, 16'h0, 26'h0, 1'b0, 20, ok);
    chkb("rtype_accepted", ok, 1'b1);
    send(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h000_0100, 1'b1, 20, ok);
    chkb("j_accepted", ok, 1'b1);
    wait_done(d0 + 1);
    chk("rj_wc", 32'(word_count), 32'h2);
    chk("rj_writes", wr_cnt - w0, 32'd2);

    // DEPTH limit: four words close the session, fifth is never accepted
    d0 = done_cnt; w0 = wr_cnt;
    do_start(32'h0000_2000);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{addr: 32'h0000_2000 + 32'(4 * i), data: 32'h2401_0000 + 32'(i)});
      send(6'h09, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'(i), 26'h0, 1'b0, 20, ok);
      chkb("depth_accepted", ok, 1'b1);
    end
    send(6'h09, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0, 1'b0, 10, ok);
    chkb("fifth_refused", ok, 1'b0);
    wait_done(d0 + 1);
    chk("depth_wc", 32'(word_count), 32'h4);
    chk("depth_writes", wr_cnt - w0, 32'd4);

    // Unknown opcode 0x3F
    d0 = done_cnt; w0 = wr_cnt;
    do_start(32'h0000_3000);
`ifdef ILLEGAL_TRAP_EN
    send(6'h3F, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0, 1'b1, 20, ok);
    chkb("illegal_accepted", ok, 1'b1);
    wait_done(d0 + 1);
    chkb("illegal_err", err, 1'b1);
    chk("illegal_writes", wr_cnt - w0, 32'd0);
`else
    exp_q.push_back('{addr: 32'h0000_3000, data: 32'hFC22_1234});
    send(6'h3F, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0, 1'b1, 20, ok);
    chkb("illegal_accepted", ok, 1'b1);
    wait_done(d0 + 1);
    chkb("illegal_err", err, 1'b0);
    chk("illegal_writes", wr_cnt - w0, 32'd1);
`endif

    // Reset during the write of the second word
    d0 = done_cnt;
    do_start(32'h0000_4000);
    chkb("restart_clears_err", err, 1'b0);
    exp_q.push_back('{addr: 32'h0000_4000, data: 32'h2401_0007});
    send(6'h09, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0007, 26'h0, 1'b0, 20, ok);
    send(6'h09, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0008, 26'h0, 1'b0, 20, ok);
    chkb("second_in_write", imem_we, 1'b1);
    rst = 1'b1;
    #1;
    chkb("abort_we", imem_we, 1'b0);
    chk("abort_addr", imem_addr, 32'h0);
    chk("abort_data", imem_wdata, 32'h0);
    chkb("abort_busy", busy, 1'b0);
    chkb("abort_in_ready", in_ready, 1'b0);
    chk("abort_wc", 32'(word_count), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    w0 = wr_cnt;
    send(6'h09, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0009, 26'h0, 1'b1, 8, ok);
    chkb("post_reset_refused", ok, 1'b0);
    chk("post_reset_writes", wr_cnt - w0, 32'd0);
    chk("post_reset_done", done_cnt, d0);

    // Address wrap, lui with rs forced to zero, jal
    d0 = done_cnt; w0 = wr_cnt;
    do_start(32'hFFFF_FFFC);
    exp_q.push_back('{addr: 32'hFFFF_FFFC, data: 32'h3C03_ABCD});
    exp_q.push_back('{addr: 32'h0000_0000, data: 32'h1FFF_FFFF});
    send(6'h0F, 5'd7, 5'd3, 5'd0, 5'd0, 6'h00, 16'hABCD, 26'h0, 1'b0, 20, ok);
    send(6'h07, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h3FF_FFFF, 1'b1, 20, ok);
    wait_done(d0 + 1);
    chk("wrap_writes", wr_cnt - w0, 32'd2);
    chkb("wrap_err", err, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 Parameter DEPTH, default 256, maximum number of instruction words loaded per session.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  begins a load session when sampled high in IDLE.
REQ-005 base_addr  input  32  byte address of the first instruction word; sampled on start.
REQ-006 in_valid / in_ready  input / output  1 / 1  field-bundle handshake; transfer occurs when both are high.
REQ-007 in_opcode, in_func  input  6 each  instruction opcode and R-type function code.
REQ-008 in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-009 in_imm  input  16; in_target  input  26  I-type immediate and J-type target.
REQ-010 in_last  input  1  marks the final bundle of a session; qualified by the handshake.
REQ-011 imem_we  output  1; imem_addr  output  32; imem_wdata  output  32  instruction-memory write port.
REQ-012 busy, done, err  output  1 each; word_count  output  $clog2(DEPTH)+1  words written this session.

Function
REQ-013 Encoding SHALL be [31:26] opcode; R-type (opcode 0x03) rs[25:21] rt[20:16] rd[15:11] shamt[10:6] func[5:0]; J-type (0x02 j, 0x07 jal) target[25:0]; I-type (0x09,0x0C,0x0E,0x05,0x04,0x22,0x12,0x28,0x2B) rs, rt, imm[15:0]; lui (0x0F) rt, imm, rs forced to 0.
REQ-014 The FSM SHALL have states IDLE, ACCEPT, WRITE, DONE, with transitions: IDLE->ACCEPT on start; ACCEPT->WRITE on handshake; WRITE->DONE if in_last was captured or word_count reaches DEPTH, else WRITE->ACCEPT; DONE->IDLE unconditionally.
REQ-015 in_ready SHALL be high only in ACCEPT; the bundle SHALL be encoded and registered on the accepting edge.
REQ-016 imem_we SHALL be high for exactly one cycle in WRITE, with imem_addr = base_addr + 4*word_count and the encoded word on imem_wdata; word_count increments at the end of that cycle.
REQ-017 Latency handshake-to-write SHALL be 1 cycle; throughput SHALL be one word per 2 cycles.
REQ-018 busy SHALL be high in ACCEPT and WRITE; done SHALL be a one-cycle pulse in DONE.
REQ-019 start while not in IDLE SHALL be ignored; start in IDLE SHALL clear word_count and err.
REQ-020 The write of the DEPTH-th word SHALL end the session even if in_last is low; no further bundle is accepted.
REQ-021 Address arithmetic SHALL wrap modulo 2^32 without error.
REQ-022 imem_we, imem_addr and imem_wdata SHALL be low / zero outside WRITE.

Reset
REQ-023 rst SHALL force IDLE and clear in_ready, imem_we, imem_addr, imem_wdata, busy, done, err and word_count to 0 immediately.
REQ-024 Reset asserted mid-session SHALL abort it with no partial or further write; a new start is required afterwards.

Configuration
REQ-025 Macro ILLEGAL_TRAP_EN: when defined, an accepted opcode outside REQ-013 SHALL NOT be written, SHALL set err (sticky until next start) and SHALL move the FSM to DONE; when undefined, it SHALL be encoded as I-type and written normally, with err held at 0.

Structure
REQ-026 A shared package isa_pkg SHALL hold the opcode and func constants (0x08 jr, 0x21 lwn, 0x13 swn), field bit positions, and the FSM state typedef, shared with the decoder.
REQ-027 Combinational encoding SHALL live in one sub-module, instr_field_encoder, which also outputs an illegal flag.

Verification
REQ-028 start, base_addr=0x0000_0000; addi with rs=1, rt=2, imm=0x0005, in_last=1 -> one write, addr 0x0, data 0x2422_0005, done pulse, word_count=1.
REQ-029 R-type opcode 0x03 with rs=3, rt=4, rd=5, func=0x21, then j with target 0x100 -> data 0x0C64_2821 at base, then 0x0800_0100 at base+4.
REQ-030 DEPTH=4, five bundles offered with in_last=0 -> exactly 4 writes, done after the 4th, and the 5th bundle is never acknowledged (in_ready stays low).
REQ-031 ILLEGAL_TRAP_EN defined, opcode 0x3F -> no imem_we, err=1, done pulse; repeat undefined -> write 0xFC00_0000 | fields, err=0.
REQ-032 Assert rst in WRITE of the 2nd word -> imem_we drops at once, all outputs 0, and no write until a new start.
REQ-033 base_addr=0xFFFF_FFFC, two words -> addresses 0xFFFF_FFFC then 0x0000_0000.
